// File: rtl/multi_code_decoder_pkg.sv
// Shared constants and types for the multi-code receive decoder.
// Mode encodings, FSM state enum and the Excess-3 offset.
package multi_code_decoder_pkg;

    localparam logic [1:0] MODE_BIN  = 2'b00;
    localparam logic [1:0] MODE_GRAY = 2'b01;
    localparam logic [1:0] MODE_XS3  = 2'b10;
    localparam logic [1:0] MODE_BCD  = 2'b11;

    localparam int unsigned EXCESS = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DECODE = 2'b01,
        ST_CMP    = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

endpackage

// File: rtl/multi_code_decoder_word.sv
// Per-operand decoder: latches a codeword, decodes Binary/XS3/BCD in one step
// or Gray bit-serially (MSB first) into a shift/accumulate register; flags legality.
module code_word_decoder
    import multi_code_decoder_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_DIGIT = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic                     step_i,
    input  logic [1:0]               mode_i,
    input  logic [$clog2(WIDTH)-1:0] bit_idx_i,
    input  logic [WIDTH-1:0]         code_i,
    output logic [WIDTH-1:0]         dec_o,
    output logic                     legal_o
);

    localparam logic [WIDTH-1:0] XS3_MIN = WIDTH'(EXCESS);
    localparam logic [WIDTH-1:0] XS3_MAX = WIDTH'(MAX_DIGIT + EXCESS);
    localparam logic [WIDTH-1:0] BCD_MAX = WIDTH'(MAX_DIGIT);

    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] dec_q, dec_d;
    logic             legal_q, legal_d;

    always_comb begin
        code_d  = code_q;
        dec_d   = dec_q;
        legal_d = legal_q;
        if (load_i) begin
            code_d  = code_i;
            dec_d   = '0;
            legal_d = 1'b0;
        end else if (step_i) begin
            case (mode_i)
                MODE_BIN: begin
                    dec_d   = code_q;
                    legal_d = 1'b1;
                end
                MODE_GRAY: begin
                    // Shift in the next binary bit: previous binary bit XOR current Gray bit.
                    dec_d   = {dec_q[WIDTH-2:0], dec_q[0] ^ code_q[bit_idx_i]};
                    legal_d = 1'b1;
                end
                MODE_XS3: begin
                    dec_d   = code_q - XS3_MIN;
                    legal_d = (code_q >= XS3_MIN) && (code_q <= XS3_MAX);
                end
                default: begin
                    dec_d   = code_q;
                    legal_d = (code_q <= BCD_MAX);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= '0;
            dec_q   <= '0;
            legal_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            dec_q   <= dec_d;
            legal_q <= legal_d;
        end
    end

    assign dec_o   = dec_q;
    assign legal_o = legal_q;

endmodule

// File: rtl/multi_code_decoder.sv
// Decodes a coded operand pair, flags illegal words and compares; out_valid 2 cycles
// after accept (WIDTH+1 for Gray), result held in DONE until out_ready, no overlap.
module multi_code_decoder
    import multi_code_decoder_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_DIGIT = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] code_a,
    input  logic [WIDTH-1:0] code_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dec_a,
    output logic [WIDTH-1:0] dec_b,
    output logic             err_a,
    output logic             err_b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q;
    logic [1:0]       mode_q;
    logic [CW-1:0]    bit_cnt_q;
    logic             in_ready_q, out_valid_q;
    logic [WIDTH-1:0] dec_a_q, dec_b_q;
    logic             err_a_q, err_b_q, gt_q, lt_q, eq_q;

    logic             load, step;
    logic [CW-1:0]    bit_idx;
    logic [WIDTH-1:0] raw_a, raw_b;
    logic             legal_a, legal_b;

    assign load    = (state_q == ST_IDLE) && in_valid;
    assign step    = (state_q == ST_DECODE);
    assign bit_idx = LAST_BIT - bit_cnt_q;

    code_word_decoder #(.WIDTH(WIDTH), .MAX_DIGIT(MAX_DIGIT)) u_dec_a (
        .clk(clk), .rst(rst), .load_i(load), .step_i(step), .mode_i(mode_q),
        .bit_idx_i(bit_idx), .code_i(code_a), .dec_o(raw_a), .legal_o(legal_a)
    );

    code_word_decoder #(.WIDTH(WIDTH), .MAX_DIGIT(MAX_DIGIT)) u_dec_b (
        .clk(clk), .rst(rst), .load_i(load), .step_i(step), .mode_i(mode_q),
        .bit_idx_i(bit_idx), .code_i(code_b), .dec_o(raw_b), .legal_o(legal_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_BIN;
            bit_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dec_a_q     <= '0;
            dec_b_q     <= '0;
            err_a_q     <= 1'b0;
            err_b_q     <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        mode_q     <= mode;
                        bit_cnt_q  <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (mode_q != MODE_GRAY || bit_cnt_q == LAST_BIT) begin
                        bit_cnt_q <= '0;
                        state_q   <= ST_CMP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                ST_CMP: begin
                    // An illegal operand zeroes its value and suppresses the comparison.
                    dec_a_q     <= legal_a ? raw_a : '0;
                    dec_b_q     <= legal_b ? raw_b : '0;
                    err_a_q     <= ~legal_a;
                    err_b_q     <= ~legal_b;
                    gt_q        <= legal_a && legal_b && (raw_a > raw_b);
                    lt_q        <= legal_a && legal_b && (raw_a < raw_b);
                    eq_q        <= legal_a && legal_b && (raw_a == raw_b);
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                default: begin
                    if (out_ready) begin
                        dec_a_q     <= '0;
                        dec_b_q     <= '0;
                        err_a_q     <= 1'b0;
                        err_b_q     <= 1'b0;
                        gt_q        <= 1'b0;
                        lt_q        <= 1'b0;
                        eq_q        <= 1'b0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dec_a     = dec_a_q;
    assign dec_b     = dec_b_q;
    assign err_a     = err_a_q;
    assign err_b     = err_b_q;
    assign gt        = gt_q;
    assign lt        = lt_q;
    assign eq        = eq_q;

endmodule

// File: tb/tb_multi_code_decoder.sv
// Bench for multi_code_decoder: directed vectors then random pairs against a
// reference model computed from the code definitions.
module tb_multi_code_decoder;

    localparam int W   = 4;
    localparam int MAXD = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] code_a = '0;
    logic [W-1:0] code_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] dec_a, dec_b;
    logic         err_a, err_b, gt, lt, eq;

    int vectors = 0;
    int miscompares = 0;

    multi_code_decoder #(.WIDTH(W), .MAX_DIGIT(MAXD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .code_a(code_a), .code_b(code_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .dec_a(dec_a), .dec_b(dec_b), .err_a(err_a), .err_b(err_b),
        .gt(gt), .lt(lt), .eq(eq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference decode: value and legality straight from the code definitions.
    function automatic void ref_decode(input int m, input int c, output int v, output bit ok);
        v  = c;
        ok = 1'b1;
        case (m)
            1: begin
                v = 0;
                for (int s = 0; s < W; s++) v = v ^ (c >> s);
            end
            2: begin
                v  = (c - 3) & ((1 << W) - 1);
                ok = (c >= 3) && (c <= MAXD + 3);
            end
            3: ok = (c <= MAXD);
            default: ;
        endcase
    endfunction

    task automatic check_outputs(input string tag, input int ea, input int eb,
                                 input int xerr_a, input int xerr_b,
                                 input int xgt, input int xlt, input int xeq);
        chk({tag, ".dec_a"}, int'(dec_a), ea);
        chk({tag, ".dec_b"}, int'(dec_b), eb);
        chk({tag, ".err_a"}, int'(err_a), xerr_a);
        chk({tag, ".err_b"}, int'(err_b), xerr_b);
        chk({tag, ".gt"}, int'(gt), xgt);
        chk({tag, ".lt"}, int'(lt), xlt);
        chk({tag, ".eq"}, int'(eq), xeq);
    endtask

    task automatic run_pair(input string tag, input int m, input int a, input int b, input int hold);
        int va, vb, xa, xb, xgt, xlt, xeq, lat, edges;
        bit oka, okb;
        ref_decode(m, a, va, oka);
        ref_decode(m, b, vb, okb);
        xa  = oka ? va : 0;
        xb  = okb ? vb : 0;
        xgt = (oka && okb && va > vb) ? 1 : 0;
        xlt = (oka && okb && va < vb) ? 1 : 0;
        xeq = (oka && okb && va == vb) ? 1 : 0;
        lat = (m == 1) ? W + 1 : 2;

        @(negedge clk);
        chk({tag, ".in_ready_idle"}, int'(in_ready), 1);
        in_valid = 1'b1;
        mode     = 2'(m);
        code_a   = W'(a);
        code_b   = W'(b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode     = 2'($urandom_range(0, 3));
        code_a   = W'($urandom);
        code_b   = W'($urandom);
        edges = 0;
        while (edges < 20) begin
            @(posedge clk);
            edges++;
            #1;
            if (out_valid) break;
        end
        chk({tag, ".latency"}, edges, lat);

        @(negedge clk);
        chk({tag, ".in_ready_busy"}, int'(in_ready), 0);
        check_outputs(tag, xa, xb, oka ? 0 : 1, okb ? 0 : 1, xgt, xlt, xeq);

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            mode     = 2'($urandom_range(0, 3));
            code_a   = W'($urandom);
            code_b   = W'($urandom);
            @(negedge clk);
            chk({tag, ".hold_valid"}, int'(out_valid), 1);
            chk({tag, ".hold_in_ready"}, int'(in_ready), 0);
            check_outputs({tag, ".hold"}, xa, xb, oka ? 0 : 1, okb ? 0 : 1, xgt, xlt, xeq);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".in_ready_after"}, int'(in_ready), 1);
        chk({tag, ".out_valid_after"}, int'(out_valid), 0);
        check_outputs({tag, ".cleared"}, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.in_ready", int'(in_ready), 1);
        chk("reset.out_valid", int'(out_valid), 0);
        check_outputs("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        run_pair("bin", 0, 4'b0110, 4'b0011, 0);
        run_pair("gray", 1, 4'b0111, 4'b0100, 0);
        run_pair("xs3", 2, 4'b0101, 4'b1001, 0);
        run_pair("xs3_err", 2, 4'b0001, 4'b1001, 0);
        run_pair("bcd", 3, 4'b1001, 4'b0100, 0);
        run_pair("bcd_err", 3, 4'b0110, 4'b1010, 0);
        run_pair("backpressure", 0, 4'b1100, 4'b1100, 3);

        // Reset in the middle of a Gray decode.
        @(negedge clk);
        in_valid = 1'b1;
        mode     = 2'b01;
        code_a   = 4'b1010;
        code_b   = 4'b0110;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midreset.in_ready", int'(in_ready), 1);
        chk("midreset.out_valid", int'(out_valid), 0);
        check_outputs("midreset", 0, 0, 0, 0, 0, 0, 0);
        run_pair("post_reset", 0, 4'b0101, 4'b0101, 0);

        for (int n = 0; n < 40; n++) begin
            run_pair("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
